// File: rtl/alu_cmd_controller.sv
// Purpose: command-side driver for the 8-bit combinational ALU; accumulator chaining, div/mod-by-zero and illegal-op guarding.
// Latency: response valid SETTLE_CYCLES edges after command acceptance; one op per SETTLE_CYCLES+2 cycles at best.
// Backpressure: cmd_ready_o only in IDLE; response held stable until rsp_ready_i, no new command accepted meanwhile.
module alu_cmd_controller #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [3:0]       cmd_op_i,
   input  logic [7:0]       cmd_a_i,
   input  logic [7:0]       cmd_b_i,
   input  logic             cmd_use_acc_i,
   output logic [7:0]       alu_a_o,
   output logic [7:0]       alu_b_o,
   output logic [3:0]       alu_sel_o,
   input  logic [7:0]       alu_result_i,
   input  logic [3:0]       alu_flags_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [7:0]       rsp_result_o,
   output logic [3:0]       rsp_flags_o,
   output logic             rsp_err_o,
   output logic [7:0]       acc_o,
   output logic [CNT_W-1:0] op_count_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   // Settle counter runs 0 .. SETTLE_CYCLES-1; capture happens on the edge seen at the last value.
   localparam int              SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_MOD = 4'b0100;
   localparam logic [3:0] OP_MAX = 4'b1100;

   logic [1:0]       state_q,    state_d;
   logic [SW-1:0]    cnt_q,      cnt_d;
   logic [7:0]       alu_a_q,    alu_a_d;
   logic [7:0]       alu_b_q,    alu_b_d;
   logic [3:0]       alu_sel_q,  alu_sel_d;
   logic [7:0]       rsp_res_q,  rsp_res_d;
   logic [3:0]       rsp_flg_q,  rsp_flg_d;
   logic             rsp_err_q,  rsp_err_d;
   logic [7:0]       acc_q,      acc_d;
   logic [CNT_W-1:0] op_cnt_q,   op_cnt_d;
   logic             op_err;

   // Error is judged on the operands actually driven to the ALU, not on the live command bus.
   assign op_err = (((alu_sel_q == OP_DIV) || (alu_sel_q == OP_MOD)) && (alu_b_q == 8'h00))
                   || (alu_sel_q > OP_MAX);

   // Next-state logic for the IDLE -> ISSUE -> RESP handshake sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      rsp_res_d = rsp_res_q;
      rsp_flg_d = rsp_flg_q;
      rsp_err_d = rsp_err_q;
      acc_d     = acc_q;
      op_cnt_d  = op_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               alu_a_d   = cmd_use_acc_i ? acc_q : cmd_a_i;
               alu_b_d   = cmd_b_i;
               alu_sel_d = cmd_op_i;
               cnt_d     = '0;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d = ST_RESP;
               if (op_err) begin
                  rsp_res_d = 8'h00;
                  rsp_flg_d = 4'b1000;
                  rsp_err_d = 1'b1;
               end else begin
                  rsp_res_d = alu_result_i;
                  rsp_flg_d = alu_flags_i;
                  rsp_err_d = 1'b0;
                  acc_d     = alu_result_i;
               end
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d  = ST_IDLE;
               op_cnt_d = op_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset drops any in-flight command.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         rsp_res_q <= '0;
         rsp_flg_q <= '0;
         rsp_err_q <= 1'b0;
         acc_q     <= '0;
         op_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
         rsp_res_q <= rsp_res_d;
         rsp_flg_q <= rsp_flg_d;
         rsp_err_q <= rsp_err_d;
         acc_q     <= acc_d;
         op_cnt_q  <= op_cnt_d;
      end
   end

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign rsp_valid_o  = (state_q == ST_RESP);
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_sel_o    = alu_sel_q;
   assign rsp_result_o = rsp_res_q;
   assign rsp_flags_o  = rsp_flg_q;
   assign rsp_err_o    = rsp_err_q;
   assign acc_o        = acc_q;
   assign op_count_o   = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_controller.sv
// Purpose: self-checking bench for alu_cmd_controller with a behavioural ALU on the alu_* side.
// Latency: checks response valid one edge after acceptance (SETTLE_CYCLES=1) and handshake timing.
// Backpressure: exercises stalled rsp_ready, pre-asserted rsp_ready and reset during ISSUE.
module tb_alu_cmd_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, cmd_use_acc;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a, cmd_b;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [3:0] alu_sel, alu_flags;
   logic       rsp_valid, rsp_ready, rsp_err;
   logic [7:0] rsp_result, acc;
   logic [3:0] rsp_flags;
   logic [3:0] op_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       use_acc;
      logic [7:0] res;
      logic [3:0] flg;
      logic       err;
      logic [7:0] acc;
   } vec_t;

   typedef struct {
      logic [7:0] res;
      logic [3:0] flg;
      logic       err;
      logic [7:0] acc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   vec_t tbl[14];

   always #5 clk = ~clk;

   alu_cmd_controller #(.SETTLE_CYCLES(1), .CNT_W(4)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_use_acc_i(cmd_use_acc),
      .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
      .alu_result_i(alu_result), .alu_flags_i(alu_flags),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags), .rsp_err_o(rsp_err),
      .acc_o(acc), .op_count_o(op_count)
   );

   // Behavioural ALU: flags are {zero, negative, carry, overflow}.
   logic [8:0] m_sum;
   logic [7:0] m_r;
   logic       m_c, m_v, m_force;
   always_comb begin
      m_sum = '0; m_r = '0; m_c = 1'b0; m_v = 1'b0; m_force = 1'b0;
      case (alu_sel)
         4'b0000: begin
            m_sum = {1'b0, alu_a} + {1'b0, alu_b};
            m_r   = m_sum[7:0];
            m_c   = m_sum[8];
            m_v   = (alu_a[7] == alu_b[7]) && (m_r[7] != alu_a[7]);
         end
         4'b0001: begin
            m_r = alu_a - alu_b;
            m_c = alu_a < alu_b;
            m_v = (alu_a[7] != alu_b[7]) && (m_r[7] != alu_a[7]);
         end
         4'b0011: if (alu_b != 0) m_r = alu_a / alu_b; else begin m_r = 8'hFF; m_force = 1'b1; end
         4'b0100: if (alu_b != 0) m_r = alu_a % alu_b; else begin m_r = 8'hFF; m_force = 1'b1; end
         4'b1100: m_r = ~alu_b;
         default: m_r = alu_a ^ alu_b;
      endcase
      alu_result = m_r;
      alu_flags  = m_force ? 4'hF : {(m_r == 8'h00), m_r[7], m_c, m_v};
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Response scoreboard: a handshake is seen at the negedge preceding its accepting edge.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp actual=%0h required=none", rsp_result);
         end else begin
            mon_e = sbq.pop_front();
            chk("rsp_result", 64'(rsp_result), 64'(mon_e.res));
            chk("rsp_flags",  64'(rsp_flags),  64'(mon_e.flg));
            chk("rsp_err",    64'(rsp_err),    64'(mon_e.err));
            chk("acc",        64'(acc),        64'(mon_e.acc));
         end
      end
   end

   task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input exp_t e, input logic [7:0] exp_alu_a,
                          input int stall, input bit pre_rdy);
      int w = 0;
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc; cmd_valid = 1'b1;
      rsp_ready = pre_rdy;
      while (!cmd_ready && w < 50) begin
         @(posedge clk); #1; w++;
      end
      chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      sbq.push_back(e);
      @(posedge clk); #1;
      if (stall > 0) begin
         cmd_op = ~op; cmd_a = 8'hAA; cmd_b = 8'h55;
      end else begin
         cmd_valid = 1'b0;
      end
      chk("alu_a",          64'(alu_a),     64'(exp_alu_a));
      chk("alu_b",          64'(alu_b),     64'(b));
      chk("alu_sel",        64'(alu_sel),   64'(op));
      chk("issue_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("issue_cmd_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
      chk("latency_rsp_valid", 64'(rsp_valid), 64'd1);
      for (int k = 0; k < stall; k++) begin
         chk("stall_result",    64'(rsp_result), 64'(e.res));
         chk("stall_rsp_valid", 64'(rsp_valid),  64'd1);
         chk("stall_cmd_ready", 64'(cmd_ready),  64'd0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] macc;
      logic [3:0] cnt_before;
      exp_t e;

      tbl[0]  = '{4'b0000, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 1'b0, 8'h80};
      tbl[1]  = '{4'b0001, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0110, 1'b0, 8'hFF};
      tbl[2]  = '{4'b0011, 8'h10, 8'h00, 1'b0, 8'h00, 4'b1000, 1'b1, 8'hFF};
      tbl[3]  = '{4'b1110, 8'h10, 8'h00, 1'b0, 8'h00, 4'b1000, 1'b1, 8'hFF};
      tbl[4]  = '{4'b0000, 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000, 1'b0, 8'h08};
      tbl[5]  = '{4'b0000, 8'h77, 8'h02, 1'b1, 8'h0A, 4'b0000, 1'b0, 8'h0A};
      tbl[6]  = '{4'b0011, 8'h64, 8'h07, 1'b0, 8'h0E, 4'b0000, 1'b0, 8'h0E};
      tbl[7]  = '{4'b0100, 8'h64, 8'h07, 1'b0, 8'h02, 4'b0000, 1'b0, 8'h02};
      tbl[8]  = '{4'b0100, 8'h64, 8'h00, 1'b0, 8'h00, 4'b1000, 1'b1, 8'h02};
      tbl[9]  = '{4'b1101, 8'h12, 8'h34, 1'b0, 8'h00, 4'b1000, 1'b1, 8'h02};
      tbl[10] = '{4'b1111, 8'h12, 8'h34, 1'b0, 8'h00, 4'b1000, 1'b1, 8'h02};
      tbl[11] = '{4'b1100, 8'h00, 8'h0F, 1'b0, 8'hF0, 4'b0100, 1'b0, 8'hF0};
      tbl[12] = '{4'b0000, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010, 1'b0, 8'h00};
      tbl[13] = '{4'b0001, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001, 1'b0, 8'h7F};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
      cmd_use_acc = 1'b0; rsp_ready = 1'b0;
      #3;
      chk("reset_outputs", 64'({alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_flags,
                                rsp_err, acc, op_count}), 64'd0);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      macc = 8'h00;
      for (int i = 0; i < 14; i++) begin
         e = '{tbl[i].res, tbl[i].flg, tbl[i].err, tbl[i].acc};
         run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].use_acc, e,
                 tbl[i].use_acc ? macc : tbl[i].a, 0, 1'b0);
         macc = tbl[i].acc;
      end
      chk("op_count_table", 64'(op_count), 64'd14);

      // Stalled response with extra command traffic during ISSUE/RESP.
      cnt_before = op_count;
      e = '{8'h20, 4'b0000, 1'b0, 8'h20};
      run_cmd(4'b0001, 8'h30, 8'h10, 1'b0, e, 8'h30, 5, 1'b0);
      chk("op_count_stall", 64'(op_count), 64'(cnt_before + 4'd1));
      repeat (2) @(posedge clk);
      #1;
      chk("op_count_stall_once", 64'(op_count), 64'(cnt_before + 4'd1));
      chk("no_extra_rsp", 64'(rsp_valid), 64'd0);

      // rsp_ready already high when rsp_valid rises; op_count wraps 15 -> 0.
      e = '{8'h0F, 4'b0000, 1'b0, 8'h0F};
      run_cmd(4'b0010, 8'hF0, 8'hFF, 1'b0, e, 8'hF0, 0, 1'b1);
      chk("op_count_wrap", 64'(op_count), 64'd0);
      e = '{8'h02, 4'b0000, 1'b0, 8'h02};
      run_cmd(4'b0000, 8'h01, 8'h01, 1'b0, e, 8'h01, 0, 1'b0);
      chk("op_count_after_wrap", 64'(op_count), 64'd1);

      // Reset while the command is in ISSUE: dropped, no response.
      cmd_op = 4'b0000; cmd_a = 8'h40; cmd_b = 8'h40; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("pre_reset_in_issue", 64'(cmd_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", 64'({alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_flags,
                                   rsp_err, acc, op_count}), 64'd0);
      chk("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("dropped_no_rsp", 64'(rsp_valid), 64'd0);
      end
      e = '{8'h05, 4'b0000, 1'b0, 8'h05};
      run_cmd(4'b0000, 8'h99, 8'h05, 1'b1, e, 8'h00, 0, 1'b0);
      chk("op_count_post_reset", 64'(op_count), 64'd1);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
